// File: rtl/parc_core_dpath_dmemresp_queue_if.sv
// Handshake bundle for the dmem response queue: enqueue side, dequeue side and status.
interface parc_core_dpath_dmemresp_queue_if #(
    parameter int CNT_W = 3
);
    logic             enq_val;
    logic             enq_rdy;
    logic [31:0]      enq_msg_data;
    logic [2:0]       enq_type;
    logic [1:0]       enq_offset;
    logic             flush;
    logic             deq_val;
    logic             deq_rdy;
    logic [31:0]      deq_msg_data;
    logic [CNT_W-1:0] count;
    logic             almost_full;

    modport slave (
        input  enq_val, enq_msg_data, enq_type, enq_offset, flush, deq_rdy,
        output enq_rdy, deq_val, deq_msg_data, count, almost_full
    );

    modport master (
        output enq_val, enq_msg_data, enq_type, enq_offset, flush, deq_rdy,
        input  enq_rdy, deq_val, deq_msg_data, count, almost_full
    );
endinterface

// File: rtl/parc_core_dpath_dmemresp_queue.sv
// M-stage dmem response queue: subword extraction on enqueue, DEPTH-entry circular FIFO.
// Optional same-cycle empty-queue bypass enabled by PARC_DMEMRESP_QUEUE_BYPASS_EN.
module parc_core_dpath_dmemresp_queue #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic reset,
    parc_core_dpath_dmemresp_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];

    logic [31:0] fmt_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        enq_fire, deq_fire, deq_val_reg, byp;

    // Byte lane picked by the full offset; halfword lane by offset[1] only.
    always_comb begin
        byte_sel = q.enq_msg_data[{q.enq_offset, 3'b000} +: 8];
        half_sel = q.enq_msg_data[{q.enq_offset[1], 4'b0000} +: 16];
        case (q.enq_type)
            3'd1:    fmt_data = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    fmt_data = {24'b0, byte_sel};
            3'd3:    fmt_data = {{16{half_sel[15]}}, half_sel};
            3'd4:    fmt_data = {16'b0, half_sel};
            default: fmt_data = q.enq_msg_data;
        endcase
    end

    assign q.enq_rdy   = (count_q != CNT_W'(DEPTH)) && !q.flush && reset;
    assign deq_val_reg = (count_q != '0) && !q.flush && reset;

`ifdef PARC_DMEMRESP_QUEUE_BYPASS_EN
    assign byp = (count_q == '0) && q.enq_val && q.deq_rdy && !q.flush && reset;
`else
    assign byp = 1'b0;
`endif

    assign q.deq_val      = deq_val_reg || byp;
    assign q.deq_msg_data = byp ? fmt_data : mem_q[rd_ptr_q];

    // A bypassed response completes on the deq side and is never stored.
    assign enq_fire = q.enq_val && q.enq_rdy && !byp;
    assign deq_fire = deq_val_reg && q.deq_rdy;

    assign q.count       = reset ? count_q : '0;
    assign q.almost_full = reset && (count_q >= CNT_W'(AF_LEVEL));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                mem_d[wr_ptr_q] = fmt_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (deq_fire)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_parc_core_dpath_dmemresp_queue.sv
// Bench for the dmem response queue: directed literal checks plus a randomized run
// checked every cycle against a queue-based model.
module tb_parc_core_dpath_dmemresp_queue;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
`ifdef PARC_DMEMRESP_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parc_core_dpath_dmemresp_queue_if #(.CNT_W(3)) dif();

    parc_core_dpath_dmemresp_queue #(.DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .q(dif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(logic [31:0] d, logic [2:0] t, logic [1:0] o);
        logic [31:0] b, h;
        b = (d >> (8 * o)) & 32'hFF;
        h = (d >> (16 * o[1])) & 32'hFFFF;
        case (t)
            3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    // Model: list of formatted words currently held.
    logic [31:0] mq[$];
    bit          m_rdy, m_dv, m_byp;
    logic [31:0] m_dat;

    always @(negedge clk) begin
        m_byp = BYP && reset && !dif.flush && (mq.size() == 0) && dif.enq_val && dif.deq_rdy;
        m_rdy = reset && !dif.flush && (mq.size() < DEPTH);
        m_dv  = (reset && !dif.flush && (mq.size() > 0)) || m_byp;
        m_dat = (mq.size() > 0) ? mq[0] : fmt(dif.enq_msg_data, dif.enq_type, dif.enq_offset);
        chk("m_enq_rdy", {31'b0, dif.enq_rdy}, {31'b0, m_rdy});
        chk("m_deq_val", {31'b0, dif.deq_val}, {31'b0, m_dv});
        chk("m_count", {29'b0, dif.count}, reset ? mq.size() : 0);
        chk("m_afull", {31'b0, dif.almost_full}, {31'b0, reset && (mq.size() >= AF)});
        if (m_dv) chk("m_deq_data", dif.deq_msg_data, m_dat);
        // State after the coming edge (inputs are held across it).
        if (!reset || dif.flush) mq.delete();
        else if (!m_byp) begin
            if (m_dv && dif.deq_rdy) void'(mq.pop_front());
            if (dif.enq_val && m_rdy) mq.push_back(fmt(dif.enq_msg_data, dif.enq_type, dif.enq_offset));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(bit v, logic [31:0] d, logic [2:0] t, logic [1:0] o);
        dif.enq_val = v; dif.enq_msg_data = d; dif.enq_type = t; dif.enq_offset = o;
    endtask

    task automatic sub(string name, logic [31:0] d, logic [2:0] t, logic [1:0] o, logic [31:0] exp);
        drive_enq(1'b1, d, t, o);
        dif.deq_rdy = 1'b1;
        if (BYP) begin
            #1;
            chk({name, "_dv"}, {31'b0, dif.deq_val}, 32'd1);
            chk(name, dif.deq_msg_data, exp);
            step();
            dif.enq_val = 1'b0;
        end else begin
            step();
            dif.enq_val = 1'b0;
            #1;
            chk({name, "_dv"}, {31'b0, dif.deq_val}, 32'd1);
            chk(name, dif.deq_msg_data, exp);
            step();
        end
    endtask

    initial begin
        reset = 1'b0;
        dif.flush = 1'b0;
        dif.deq_rdy = 1'b0;
        drive_enq(1'b0, 32'h0, 3'd0, 2'd0);

        // Reset held two cycles, then released.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_enq_rdy", {31'b0, dif.enq_rdy}, 32'd0);
            chk("rst_deq_val", {31'b0, dif.deq_val}, 32'd0);
            chk("rst_count", {29'b0, dif.count}, 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("rel_enq_rdy", {31'b0, dif.enq_rdy}, 32'd1);
        chk("rel_count", {29'b0, dif.count}, 32'd0);
        step();

        // Subword extraction.
        sub("lb3",  32'h80FF7F01, 3'd1, 2'd3, 32'hFFFFFF80);
        sub("lbu1", 32'h80FF7F01, 3'd2, 2'd1, 32'h0000007F);
        sub("lh2",  32'h80FF7F01, 3'd3, 2'd2, 32'hFFFF80FF);
        sub("lhu3", 32'h80FF7F01, 3'd4, 2'd3, 32'h000080FF);
        sub("lw",   32'h80FF7F01, 3'd0, 2'd2, 32'h80FF7F01);
        dif.deq_rdy = 1'b0;

        // Fill to full, reject a 5th, drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive_enq(1'b1, 32'(i), 3'd0, 2'd0);
            step();
            chk("fill_count", {29'b0, dif.count}, 32'(i));
            if (i == 3) chk("fill_afull", {31'b0, dif.almost_full}, 32'd1);
            if (i == 4) chk("full_enq_rdy", {31'b0, dif.enq_rdy}, 32'd0);
        end
        drive_enq(1'b1, 32'd5, 3'd0, 2'd0);
        step();
        chk("full_count", {29'b0, dif.count}, 32'd4);
        dif.enq_val = 1'b0;
        dif.deq_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_data", dif.deq_msg_data, 32'(i));
            step();
        end
        chk("drain_count", {29'b0, dif.count}, 32'd0);
        dif.deq_rdy = 1'b0;

        // Steady state at count 2 across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive_enq(1'b1, 32'h100 + 32'(i), 3'd0, 2'd0);
            step();
        end
        dif.deq_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_enq(1'b1, 32'h102 + 32'(k), 3'd0, 2'd0);
            #1;
            chk("wrap_data", dif.deq_msg_data, 32'h100 + 32'(k));
            chk("wrap_count", {29'b0, dif.count}, 32'd2);
            step();
        end
        dif.enq_val = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            chk("wrap_tail", dif.deq_msg_data, 32'h100 + 32'(k));
            step();
        end
        dif.deq_rdy = 1'b0;

        // Flush at count 3 with a concurrent enqueue.
        for (int i = 1; i <= 3; i++) begin
            drive_enq(1'b1, 32'h200 + 32'(i), 3'd0, 2'd0);
            step();
        end
        drive_enq(1'b1, 32'h00000BAD, 3'd0, 2'd0);
        dif.flush = 1'b1;
        #1;
        chk("flush_enq_rdy", {31'b0, dif.enq_rdy}, 32'd0);
        chk("flush_deq_val", {31'b0, dif.deq_val}, 32'd0);
        step();
        dif.flush = 1'b0;
        dif.enq_val = 1'b0;
        #1;
        chk("post_flush_count", {29'b0, dif.count}, 32'd0);
        chk("post_flush_dv", {31'b0, dif.deq_val}, 32'd0);
        drive_enq(1'b1, 32'h77, 3'd0, 2'd0);
        step();
        dif.enq_val = 1'b0;
        chk("post_flush_data", dif.deq_msg_data, 32'h77);
        dif.deq_rdy = 1'b1;
        step();
        dif.deq_rdy = 1'b0;

        // Empty-queue latency: same cycle with bypass, next cycle without.
        drive_enq(1'b1, 32'hDEADBEEF, 3'd0, 2'd0);
        dif.deq_rdy = 1'b1;
        #1;
        chk("byp_dv", {31'b0, dif.deq_val}, {31'b0, BYP});
        if (BYP) chk("byp_data", dif.deq_msg_data, 32'hDEADBEEF);
        step();
        dif.enq_val = 1'b0;
        chk("byp_count", {29'b0, dif.count}, BYP ? 32'd0 : 32'd1);
        if (!BYP) chk("nobyp_data", dif.deq_msg_data, 32'hDEADBEEF);
        step();

        // Randomized run, including mid-operation flush and reset.
        for (int c = 0; c < 3000; c++) begin
            dif.enq_val      = ($urandom_range(0, 99) < 60);
            dif.enq_msg_data = $urandom;
            dif.enq_type     = 3'($urandom_range(0, 7));
            dif.enq_offset   = 2'($urandom_range(0, 3));
            dif.deq_rdy      = ($urandom_range(0, 99) < 50);
            dif.flush        = ($urandom_range(0, 99) < 4);
            reset            = ($urandom_range(0, 99) >= 2);
            step();
        end
        reset = 1'b1;
        dif.flush = 1'b0;
        dif.enq_val = 1'b0;
        dif.deq_rdy = 1'b1;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/parc_core_dpath_dmemresp_queue.md
Name: parc_core_dpath_dmemresp_queue

Overview:
Parametrised multi-entry data-memory response queue for the 5-stage PARCv2 datapath. It generalises the single-register dmem response buffer in the M stage. It accepts raw 32-bit load responses and performs byte-lane-correct subword extraction using the load address offset. Formatted results are buffered in a DEPTH-entry FIFO with val/rdy handshakes, so M can accept responses while W or the stage itself is stalled.

Parameters:
DEPTH, 4, number of buffered entries; power of two, >= 2
AF_LEVEL, 3, occupancy at or above which almost_full asserts; range 1..DEPTH
CNT_W, 3, width of count output; must equal clog2(DEPTH+1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low (queue held cleared while reset==0)
enq_val  input  1  response valid
enq_rdy  output  1  queue can accept
enq_msg_data  input  32  raw dmem response word
enq_type  input  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw
enq_offset  input  2  load address bits [1:0]
flush  input  1  synchronous squash of all entries
deq_val  output  1  head valid
deq_rdy  input  1  consumer accepts head
deq_msg_data  output  32  formatted load result
count  output  CNT_W  current occupancy
almost_full  output  1  count >= AF_LEVEL

Behaviour:
- Transfer occurs when val && rdy are both high at a rising edge. Enqueue and dequeue are independent and may fire in the same cycle.
- Extraction is combinational on the enq side and stored already formatted. Entries hold 32 bits.
- lb/lbu select byte enq_offset: data[8*off+7 : 8*off]. lb sign-extends from bit 8*off+7; lbu zero-extends.
- lh/lhu select halfword enq_offset[1]: data[16*off1+15 : 16*off1]. enq_offset[0] is ignored. lh sign-extends; lhu zero-extends.
- lw passes the word unchanged and ignores enq_offset.
- Storage: circular buffer with wr_ptr and rd_ptr of width log2(DEPTH), plus an occupancy counter. Pointers wrap DEPTH-1 -> 0.
- enq_rdy = (count != DEPTH) && !flush && reset.
- deq_val = (count != 0) && !flush && reset.
- deq_msg_data = entry[rd_ptr]. It holds its value while deq_val && !deq_rdy.
- Full with simultaneous deq fire: enq_rdy stays 0, so there is no pass-through-when-full. count decrements to DEPTH-1.
- Empty: deq_val=0. deq_msg_data is don't-care, and the bench must not check it.
- Simultaneous enq and deq fire: count is unchanged and both pointers advance.
- flush=1: at the next edge, pointers and count go to 0. Any enqueue in that cycle is dropped, since enq_rdy is forced to 0. deq_val is forced to 0 in the flush cycle.
- Reset (reset==0 at an edge): pointers and count go to 0; storage contents are not cleared. While reset==0, enq_rdy=0, deq_val=0, count=0, almost_full=0. Reset mid-operation discards all entries. The first cycle after release shows enq_rdy=1, count=0.
- Latency without the optional feature: an entry enqueued at edge N is visible on deq at cycle N+1. Minimum latency is 1 cycle.
- almost_full is registered-equivalent: it is derived from registered count, with no combinational path from enq_val or deq_rdy.

Optional Feature:
Macro PARC_DMEMRESP_QUEUE_BYPASS_EN.
- Defined: when count==0, enq_val=1, and deq_rdy=1, the formatted enq data appears on deq_msg_data in the same cycle, with deq_val=1. The transfer completes without being written; count stays 0 and pointers do not move.
- Defined, flush or reset active: the bypass path is disabled.
- When the queue is empty and the bypass is taken, deq_val is combinationally dependent on enq_val.
- Undefined: no combinational enq->deq path; deq_val depends only on registered state.

Test Plan:
1. Reset held low for 2 cycles -> enq_rdy=0, deq_val=0, count=0. After release -> enq_rdy=1, count=0.
2. Subword extraction, one dequeue each with deq_rdy=1, data=0x80FF7F01:
   - lb off=3 -> 0xFFFFFF80
   - lbu off=1 -> 0x0000007F
   - lh off=2 -> 0xFFFF80FF
   - lhu off=3 -> 0x000080FF
   - lw -> 0x80FF7F01
3. Fill with deq_rdy=0, lw 0x1,0x2,0x3,0x4:
   - count 3 -> almost_full=1
   - count 4 -> enq_rdy=0
   - a 5th enq_val is not accepted
   - then deq_rdy=1 drains 0x1..0x4 in order
4. Wrap-around: at count=2 run continuous simultaneous enq/deq for 10 cycles -> count stays 2 and output order equals input order across pointer wrap.
5. Flush with count=3 while enq_val=1 -> next cycle count=0, deq_val=0, and the enqueued word never appears on deq.
6. Bypass feature:
   - Defined, empty queue, enq lw 0xDEADBEEF with deq_rdy=1 -> same-cycle deq_msg_data=0xDEADBEEF, count stays 0.
   - Undefined -> appears one cycle later.
